// File: rtl/flp_relu_grad_pkg.sv
// Shared floating-point definitions: default format widths and the canonical quiet NaN.
package flp_relu_grad_pkg;

  localparam int unsigned FLP_EWIDTH = 8;
  localparam int unsigned FLP_SWIDTH = 23;
  localparam int unsigned FLP_WIDTH  = FLP_EWIDTH + FLP_SWIDTH + 1;
  localparam int unsigned ZCNT_WIDTH = 32;

  // Positive sign, all-ones exponent, only the significand MSB set.
  localparam logic [FLP_WIDTH-1:0] FLP_CANON_NAN =
    {1'b0, {FLP_EWIDTH{1'b1}}, 1'b1, {(FLP_SWIDTH-1){1'b0}}};

endpackage

// File: rtl/flp_relu_grad_if.sv
// Operand/result stream bundle for the ReLU gradient block (upstream and downstream handshakes).
interface flp_relu_grad_if
  import flp_relu_grad_pkg::*;
#(
  parameter int unsigned EWIDTH = FLP_EWIDTH,
  parameter int unsigned SWIDTH = FLP_SWIDTH
);
  localparam int unsigned W = EWIDTH + SWIDTH + 1;

  logic [W-1:0]        x;
  logic [W-1:0]        g;
  logic                l;
  logic [EWIDTH-2:0]   e;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        r;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output x, g, l, e, in_valid, out_ready,
    input  in_ready, r, out_valid
  );

  modport slave (
    input  x, g, l, e, in_valid, out_ready,
    output in_ready, r, out_valid
  );
endinterface

// File: rtl/flp_exp_scale.sv
// Exponent decrement by D with underflow flag (result <= 0 in EWIDTH+1 bits); shared with forward ReLU.
module flp_exp_scale
  import flp_relu_grad_pkg::*;
#(
  parameter int unsigned EWIDTH = FLP_EWIDTH
) (
  input  logic [EWIDTH-1:0] i_exp,
  input  logic [EWIDTH-1:0] i_dec,
  output logic [EWIDTH-1:0] o_exp_c,
  output logic              o_uflow_c
);
  logic [EWIDTH:0] diff;

  always_comb begin
    diff      = {1'b0, i_exp} - {1'b0, i_dec};
    o_uflow_c = diff[EWIDTH] || (diff == '0);
    o_exp_c   = diff[EWIDTH-1:0];
  end
endmodule

// File: rtl/flp_pack.sv
// Reassembles sign/exponent/significand into a packed float.
module flp_pack
  import flp_relu_grad_pkg::*;
#(
  parameter int unsigned EWIDTH = FLP_EWIDTH,
  parameter int unsigned SWIDTH = FLP_SWIDTH,
  localparam int unsigned W = EWIDTH + SWIDTH + 1
) (
  input  logic              i_sign,
  input  logic [EWIDTH-1:0] i_exp,
  input  logic [SWIDTH-1:0] i_man,
  output logic [W-1:0]      o_w_c
);
  assign o_w_c = {i_sign, i_exp, i_man};
endmodule

// File: rtl/flp_unpack.sv
// Splits a packed float into sign/exponent/significand and classifies it.
module flp_unpack
  import flp_relu_grad_pkg::*;
#(
  parameter int unsigned EWIDTH = FLP_EWIDTH,
  parameter int unsigned SWIDTH = FLP_SWIDTH,
  localparam int unsigned W = EWIDTH + SWIDTH + 1
) (
  input  logic [W-1:0]      i_w,
  output logic              o_sign_c,
  output logic [EWIDTH-1:0] o_exp_c,
  output logic [SWIDTH-1:0] o_man_c,
  output logic              o_is_nan_c,
  output logic              o_is_inf_c,
  output logic              o_is_zero_c
);
  logic exp_max;
  logic man_zero;

  always_comb begin
    o_sign_c    = i_w[W-1];
    o_exp_c     = i_w[W-2:SWIDTH];
    o_man_c     = i_w[SWIDTH-1:0];
    exp_max     = &o_exp_c;
    man_zero    = (o_man_c == '0);
    o_is_nan_c  = exp_max && !man_zero;
    o_is_inf_c  = exp_max && man_zero;
    o_is_zero_c = (o_exp_c == '0) && man_zero;
  end
endmodule

// File: rtl/flp_relu_grad.sv
// flp_relu_grad: two-stage ReLU / leaky-ReLU backward pass on packed floats with valid/ready flow control.
// Defining FLP_RELU_GRAD_STATS_EN adds i_sclr/o_zcnt, a counter of zero-valued delivered results.
module flp_relu_grad
  import flp_relu_grad_pkg::*;
#(
  parameter int unsigned EWIDTH = FLP_EWIDTH,
  parameter int unsigned SWIDTH = FLP_SWIDTH,
  localparam int unsigned W = EWIDTH + SWIDTH + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
`ifdef FLP_RELU_GRAD_STATS_EN
  input  logic                  i_sclr,
  output logic [ZCNT_WIDTH-1:0] o_zcnt,
`endif
  input  logic [W-1:0]          i_x,
  input  logic [W-1:0]          i_g,
  input  logic                  i_l,
  input  logic [EWIDTH-2:0]     i_e,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [W-1:0]          o_r,
  output logic                  o_valid,
  input  logic                  i_ready
);
  localparam logic [W-1:0] CANON_NAN = (W == FLP_WIDTH) ? W'(FLP_CANON_NAN)
    : {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
  localparam logic [EWIDTH-1:0] DEC_BASE = {1'b1, {(EWIDTH-1){1'b0}}};

  flp_relu_grad_if #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH)) bus ();

  assign bus.x         = i_x;
  assign bus.g         = i_g;
  assign bus.l         = i_l;
  assign bus.e         = i_e;
  assign bus.in_valid  = i_valid;
  assign bus.out_ready = i_ready;
  assign o_ready       = bus.in_ready;
  assign o_r           = bus.r;
  assign o_valid       = bus.out_valid;

  logic              x_sign, x_nan, x_inf, x_zero;
  logic [EWIDTH-1:0] x_exp;
  logic [SWIDTH-1:0] x_man;
  logic              g_sign, g_nan, g_inf, g_zero;
  logic [EWIDTH-1:0] g_exp;
  logic [SWIDTH-1:0] g_man;
  logic [EWIDTH-1:0] dec_c;
  logic [EWIDTH-1:0] scl_exp_c;
  logic              uflow_c;
  logic [W-1:0]      scaled_c;
  logic [W-1:0]      res_c;
  logic              unused_x_fields;

  flp_unpack #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH)) u_unpack_x (
    .i_w(bus.x), .o_sign_c(x_sign), .o_exp_c(x_exp), .o_man_c(x_man),
    .o_is_nan_c(x_nan), .o_is_inf_c(x_inf), .o_is_zero_c(x_zero)
  );

  flp_unpack #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH)) u_unpack_g (
    .i_w(bus.g), .o_sign_c(g_sign), .o_exp_c(g_exp), .o_man_c(g_man),
    .o_is_nan_c(g_nan), .o_is_inf_c(g_inf), .o_is_zero_c(g_zero)
  );

  // Only the sign and NaN class of the activation steer the gradient.
  assign unused_x_fields = ^{x_exp, x_man, x_inf, x_zero};

  // D = 2^(EWIDTH-1) - i_e spans 1..2^(EWIDTH-1), so it fits in EWIDTH bits.
  assign dec_c = DEC_BASE - {1'b0, bus.e};

  flp_exp_scale #(.EWIDTH(EWIDTH)) u_exp_scale (
    .i_exp(g_exp), .i_dec(dec_c), .o_exp_c(scl_exp_c), .o_uflow_c(uflow_c)
  );

  flp_pack #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH)) u_pack (
    .i_sign(g_sign), .i_exp(scl_exp_c), .i_man(g_man), .o_w_c(scaled_c)
  );

  // S1 decode/scale: gradient selection by activation class and leaky mode.
  always_comb begin
    res_c = bus.g;
    if (x_nan) begin
      res_c = CANON_NAN;
    end else if (!x_sign) begin
      res_c = bus.g;
    end else if (!bus.l) begin
      res_c = '0;
    end else if (g_nan || g_inf || g_zero) begin
      res_c = bus.g;
    end else if (uflow_c) begin
      res_c = {g_sign, {(W-1){1'b0}}};
    end else begin
      res_c = scaled_c;
    end
  end

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_r_q, s1_r_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_r_q, s2_r_d;
  logic         s1_adv_c, s2_adv_c;

  // Elastic two-register pipeline; a stalled S2 holds its result untouched.
  always_comb begin
    s2_adv_c   = !s2_valid_q || bus.out_ready;
    s1_adv_c   = !s1_valid_q || s2_adv_c;
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s2_valid_d = s2_valid_q;
    s2_r_d     = s2_r_q;
    if (s1_adv_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_r_d = res_c;
    end
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_r_d = s1_r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_r_q     <= s1_r_d;
      s2_valid_q <= s2_valid_d;
      s2_r_q     <= s2_r_d;
    end
  end

  assign bus.in_ready  = s1_adv_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.r         = s2_r_q;

`ifdef FLP_RELU_GRAD_STATS_EN
  logic [ZCNT_WIDTH-1:0] zcnt_q, zcnt_d;

  // Clear wins over a same-cycle count; the counter wraps naturally.
  always_comb begin
    zcnt_d = zcnt_q;
    if (i_sclr) begin
      zcnt_d = '0;
    end else if (s2_valid_q && bus.out_ready && (s2_r_q[W-2:0] == '0)) begin
      zcnt_d = zcnt_q + ZCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) zcnt_q <= '0;
    else       zcnt_q <= zcnt_d;
  end

  assign o_zcnt = zcnt_q;
`endif

endmodule

// File: tb/tb_flp_relu_grad.sv
// Self-checking bench for flp_relu_grad: directed vectors, stall/back-to-back/random streams, reset.
module tb_flp_relu_grad;
  import flp_relu_grad_pkg::*;

  localparam int unsigned EW = FLP_EWIDTH;
  localparam int unsigned SW = FLP_SWIDTH;
  localparam int unsigned W  = FLP_WIDTH;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  flp_relu_grad_if #(.EWIDTH(EW), .SWIDTH(SW)) bus ();

`ifdef FLP_RELU_GRAD_STATS_EN
  logic        sclr;
  logic [31:0] zcnt;
`endif

  flp_relu_grad #(.EWIDTH(EW), .SWIDTH(SW)) dut (
    .clk     (clk),
    .nrst    (nrst),
`ifdef FLP_RELU_GRAD_STATS_EN
    .i_sclr  (sclr),
    .o_zcnt  (zcnt),
`endif
    .i_x     (bus.x),
    .i_g     (bus.g),
    .i_l     (bus.l),
    .i_e     (bus.e),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .o_r     (bus.r),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Behavioural model of the gradient rules, in plain integer arithmetic.
  function automatic logic [31:0] ref_grad(input logic [31:0] x, input logic [31:0] g,
                                           input logic l, input logic [6:0] e);
    int ne;
    if (x[30:23] == 8'hFF && x[22:0] != 23'h0) return 32'h7FC00000;
    if (!x[31]) return g;
    if (!l) return 32'h0;
    if (g[30:23] == 8'hFF || g[30:0] == 31'h0) return g;
    ne = int'(g[30:23]) - (128 - int'(e));
    if (ne <= 0) return {g[31], 31'h0};
    return {g[31], ne[7:0], g[22:0]};
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[30:23] = 8'hFF;
      1: w[30:0]  = 31'h0;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rand_g();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[30:23] = 8'hFF;
      1: w[30:0]  = 31'h0;
      2: w[30:23] = 8'($urandom_range(0, 12));
      default: ;
    endcase
    return w;
  endfunction

  // Drive one cycle from a negedge, observe just after, then advance to the next negedge.
  task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] g,
                       input logic l, input logic [6:0] e, input logic rdy,
                       output logic acc, output logic ordy, output logic dv, output logic [31:0] dr);
    bus.in_valid  = v;
    bus.x         = x;
    bus.g         = g;
    bus.l         = l;
    bus.e         = e;
    bus.out_ready = rdy;
    #1;
    ordy = bus.in_ready;
    acc  = v & ordy;
    dv   = bus.out_valid;
    dr   = bus.r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc, ordy, dv;
    logic [31:0] dr;
    nrst = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b0, acc, ordy, dv, dr);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b0, acc, ordy, dv, dr);
    checks++;
    if (dv !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", dv); end
    checks++;
    if (dr !== 32'h0) begin failures++; $display("FAIL reset_o_r got=%h exp=00000000", dr); end
`ifdef FLP_RELU_GRAD_STATS_EN
    checks++;
    if (zcnt !== 32'h0) begin failures++; $display("FAIL reset_zcnt got=%0d exp=0", zcnt); end
`endif
    nrst = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    checks++;
    if (ordy !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", ordy); end
  endtask

  task automatic test_directed();
    logic [31:0] vx[6] = '{32'h3F800000, 32'hBF800000, 32'hBF800000,
                           32'hBF800000, 32'hBF800000, 32'h7FC00001};
    logic [31:0] vg[6] = '{32'h40000000, 32'h40000000, 32'h40000000,
                           32'h80800000, 32'hFF800000, 32'h0};
    logic        vl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] vr[6] = '{32'h40000000, 32'h00000000, 32'h3D000000,
                           32'h80000000, 32'hFF800000, 32'h7FC00000};
    logic acc, ordy, dv;
    logic [31:0] dr;
    vg[5] = $urandom();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vx[i], vg[i], vl[i], 7'h7A, 1'b1, acc, ordy, dv, dr);
      checks++;
      if (acc !== 1'b1) begin failures++; $display("FAIL directed_accept[%0d] got=%b exp=1", i, acc); end
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
      checks++;
      if (dv !== 1'b0) begin failures++; $display("FAIL directed_early_valid[%0d] got=%b exp=0", i, dv); end
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
      checks++;
      if (dv !== 1'b1 || dr !== vr[i]) begin
        failures++;
        $display("FAIL directed_result[%0d] got valid=%b r=%h exp valid=1 r=%h", i, dv, dr, vr[i]);
      end
    end
  endtask

  // mode 0: fixed stall window cycles 3..7; mode 1: back-to-back; mode 2: random valid/ready.
  task automatic test_stream(input string name, input int n, input int mode);
    int sent = 0;
    int got  = 0;
    int c    = 0;
    logic v, rdy, l, acc, ordy, dv, exp_ordy;
    logic [31:0] x, g, dr, er;
    logic [6:0]  e;
    logic        pdv  = 1'b0;
    logic        prdy = 1'b1;
    logic [31:0] pr   = 32'h0;
    while (got < n && c < 4000) begin
      case (mode)
        0:       begin v = (sent < n); rdy = !(c >= 3 && c <= 7); end
        1:       begin v = (sent < n); rdy = 1'b1; end
        default: begin v = (sent < n) && ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 2) != 0); end
      endcase
      x = rand_x();
      g = rand_g();
      l = 1'($urandom_range(0, 1));
      e = 7'($urandom());
      exp_ordy = !((sent - got) == 2 && !rdy);
      cycle(v, x, g, l, e, rdy, acc, ordy, dv, dr);
      checks++;
      if (ordy !== exp_ordy) begin
        failures++;
        $display("FAIL %s_o_ready cyc=%0d got=%b exp=%b", name, c, ordy, exp_ordy);
      end
      if (pdv && !prdy) begin
        checks++;
        if (dv !== 1'b1 || dr !== pr) begin
          failures++;
          $display("FAIL %s_stall_hold cyc=%0d got valid=%b r=%h exp valid=1 r=%h", name, c, dv, dr, pr);
        end
      end
      if (dv && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra_output cyc=%0d got r=%h exp none", name, c, dr);
        end else begin
          er = exp_q.pop_front();
          if (dr !== er) begin
            failures++;
            $display("FAIL %s_result cyc=%0d got=%h exp=%h", name, c, dr, er);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(ref_grad(x, g, l, e));
        sent++;
      end
      pdv  = dv;
      prdy = rdy;
      pr   = dr;
      c++;
    end
    checks++;
    if (got != n || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_count got=%0d pending=%0d exp=%0d pending=0", name, got, exp_q.size(), n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic acc, ordy, dv;
    logic [31:0] dr, x, g, er;
    cycle(1'b1, 32'hBF800000, 32'h40000000, 1'b0, 7'h0, 1'b0, acc, ordy, dv, dr);
    cycle(1'b1, 32'hBF800000, 32'h40400000, 1'b0, 7'h0, 1'b0, acc, ordy, dv, dr);
    nrst = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b0, acc, ordy, dv, dr);
    nrst = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    checks++;
    if (dv !== 1'b0) begin failures++; $display("FAIL midreset_o_valid got=%b exp=0", dv); end
    checks++;
    if (ordy !== 1'b1) begin failures++; $display("FAIL midreset_o_ready got=%b exp=1", ordy); end
`ifdef FLP_RELU_GRAD_STATS_EN
    checks++;
    if (zcnt !== 32'h0) begin failures++; $display("FAIL midreset_zcnt got=%0d exp=0", zcnt); end
`endif
    x  = {1'b1, 31'($urandom())};
    g  = 32'h41200000;
    er = ref_grad(x, g, 1'b1, 7'h7C);
    cycle(1'b1, x, g, 1'b1, 7'h7C, 1'b1, acc, ordy, dv, dr);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    checks++;
    if (dv !== 1'b0) begin failures++; $display("FAIL midreset_early_valid got=%b exp=0", dv); end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    checks++;
    if (dv !== 1'b1 || dr !== er) begin
      failures++;
      $display("FAIL midreset_result got valid=%b r=%h exp valid=1 r=%h", dv, dr, er);
    end
  endtask

`ifdef FLP_RELU_GRAD_STATS_EN
  task automatic test_stats();
    logic acc, ordy, dv, l;
    logic [31:0] dr, x, g;
    logic [6:0]  e;
    int zeros = 0;
    sclr = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    sclr = 1'b0;
    checks++;
    if (zcnt !== 32'h0) begin failures++; $display("FAIL stats_sclr got=%0d exp=0", zcnt); end
    for (int i = 0; i < 10; i++) begin
      x = (i == 0) ? 32'hBF800000 : rand_x();
      g = rand_g();
      l = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      e = 7'($urandom());
      if (ref_grad(x, g, l, e) ==? 32'b?0000000000000000000000000000000) zeros++;
      cycle(1'b1, x, g, l, e, 1'b1, acc, ordy, dv, dr);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    checks++;
    if (zcnt !== 32'(zeros)) begin failures++; $display("FAIL stats_count got=%0d exp=%0d", zcnt, zeros); end
    cycle(1'b1, 32'hBF800000, 32'h40000000, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    sclr = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 7'h0, 1'b1, acc, ordy, dv, dr);
    sclr = 1'b0;
    checks++;
    if (dv !== 1'b1 || zcnt !== 32'h0) begin
      failures++;
      $display("FAIL stats_sclr_collide got valid=%b zcnt=%0d exp valid=1 zcnt=0", dv, zcnt);
    end
  endtask
`endif

  initial begin
`ifdef FLP_RELU_GRAD_STATS_EN
    sclr = 1'b0;
`endif
    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.g         = '0;
    bus.l         = 1'b0;
    bus.e         = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stream("stall", 8, 0);
    test_stream("b2b", 40, 1);
    test_stream("random", 300, 2);
    test_reset_midstream();
`ifdef FLP_RELU_GRAD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flp_relu_grad.md
FLP_RELU_GRAD -- requirements
Module: flp_relu_grad

Interface
REQ-001 SHALL have parameter EWIDTH, default 8, meaning exponent width.
REQ-002 SHALL have parameter SWIDTH, default 23, meaning significand width; word width W = EWIDTH+SWIDTH+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_x, input, W bits: forward-pass activation input (pre-ReLU value).
REQ-006 SHALL have port i_g, input, W bits: upstream gradient.
REQ-007 SHALL have port i_l, input, 1 bit: =1 leaky ReLU, =0 ReLU.
REQ-008 SHALL have port i_e, input, EWIDTH-1 bits: leaky exponent code; decrement D = 2^(EWIDTH-1) - i_e, so D is 1..2^(EWIDTH-1).
REQ-009 SHALL have port i_valid, input, 1 bit, and port o_ready, output, 1 bit: upstream handshake.
REQ-010 SHALL have port o_r, output, W bits: gradient result.
REQ-011 SHALL have port o_valid, output, 1 bit, and port i_ready, input, 1 bit: downstream handshake.

Function
REQ-012 A transfer SHALL occur on any edge with valid&ready high; i_x, i_g, i_l, i_e SHALL be sampled together on the upstream transfer.
REQ-013 SHALL be a 2-stage pipeline (S1 decode/scale, S2 output register); latency 2 cycles from upstream transfer to o_valid with i_ready held high.
REQ-014 Throughput SHALL be one result per cycle while i_ready=1.
REQ-015 S2 SHALL advance when !S2.valid or i_ready; S1 SHALL advance when !S1.valid or S2 advances; o_ready = !S1.valid or S2 advances (combinational from i_ready).
REQ-016 While o_valid=1 and i_ready=0, o_r and o_valid SHALL hold stable; no result SHALL be dropped, duplicated or reordered.
REQ-017 If i_x is NaN, the result SHALL be canonical quiet NaN (sign 0, exponent all ones, significand MSB only).
REQ-018 Otherwise, if i_x sign=0 (including +0 and +inf), the result SHALL be i_g unchanged.
REQ-019 Otherwise, if i_x sign=1 and i_l=0, the result SHALL be +0 (all zeros).
REQ-020 Otherwise, if i_x sign=1 and i_l=1: a NaN or inf i_g SHALL pass unchanged; a zero i_g SHALL pass unchanged; else the exponent SHALL become exp(i_g)-D with significand and sign kept.
REQ-021 If exp(i_g)-D <= 0 (computed in EWIDTH+1 bits), the result SHALL be a signed zero carrying the sign of i_g.

Reset
REQ-022 With nrst=0 at an edge, S1.valid, S2.valid and o_valid SHALL be 0; o_r SHALL be 0.
REQ-023 Reset mid-stream SHALL discard all in-flight items; o_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-024 Macro FLP_RELU_GRAD_STATS_EN, when defined, SHALL add port i_sclr (input, 1 bit) and port o_zcnt (output, 32 bits).
REQ-025 With the macro defined, o_zcnt SHALL count downstream transfers whose o_r is zero of either sign; it SHALL wrap at 2^32, clear on reset, and clear on i_sclr. If i_sclr and a counted transfer occur in the same cycle, the result SHALL be 0.
REQ-026 Without the macro, these ports and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 The canonical-NaN constant and the default EWIDTH/SWIDTH SHALL reside in the shared floating-point package.
REQ-028 Exponent decrement with underflow detect SHALL be the single sub-module flp_exp_scale, reusable by the forward ReLU path.
REQ-029 Field extraction SHALL reuse the existing flp_unpack/flp_pack blocks.

Verification
REQ-030 i_x=0x3F800000, i_g=0x40000000, i_l=0, i_ready=1 -> o_r=0x40000000, o_valid 2 cycles after the transfer.
REQ-031 i_x=0xBF800000, i_g=0x40000000, i_l=0 -> o_r=0x00000000; with i_l=1, i_e=0x7A (D=6) -> o_r=0x3D000000.
REQ-032 i_x=0xBF800000, i_l=1, i_e=0x7A, i_g=0x80800000 -> o_r=0x80000000 (underflow); i_g=0xFF800000 -> 0xFF800000.
REQ-033 i_x=0x7FC00001, any i_g -> o_r=0x7FC00000.
REQ-034 Stream 8 items with i_ready low for cycles 3-7 -> o_ready low once both stages are full, o_r stable while stalled, all 8 outputs delivered in order.
REQ-035 nrst low for 1 cycle with 2 items in flight -> o_valid=0 and o_zcnt=0 next cycle; the next accepted item emerges 2 cycles after its transfer.
